// File: rtl/riscv_structures.sv
// Shared types and encodings for the execute stage and its RV-M unit.
package riscv_structures;

    typedef enum logic [1:0] {
        SRC_RF  = 2'd0,
        SRC_MEM = 2'd1,
        SRC_WB  = 2'd2
    } ex_src_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    localparam logic [2:0] BR_BEQ  = 3'd0;
    localparam logic [2:0] BR_BNE  = 3'd1;
    localparam logic [2:0] BR_BLT  = 3'd4;
    localparam logic [2:0] BR_BGE  = 3'd5;
    localparam logic [2:0] BR_BLTU = 3'd6;
    localparam logic [2:0] BR_BGEU = 3'd7;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    function automatic logic md_a_signed(input logic [2:0] f3);
        return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
    endfunction

    function automatic logic md_b_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle integer ALU.
module alu import riscv_structures::*; #(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);
    localparam int SW = $clog2(XLEN);

    logic [SW-1:0] shamt_s;
    assign shamt_s = b[SW-1:0];

    // Operation select.
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_SLL:   y = a << shamt_s;
            ALU_SLT:   y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:  y = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:   y = a ^ b;
            ALU_SRL:   y = a >> shamt_s;
            ALU_SRA:   y = $unsigned($signed(a) >>> shamt_s);
            ALU_OR:    y = a | b;
            ALU_AND:   y = a & b;
            ALU_PASSB: y = b;
            default:   y = a + b;
        endcase
    end
endmodule

// File: rtl/compare.sv
// Branch condition evaluation on the forwarded register operands.
module compare import riscv_structures::*; #(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            taken
);
    // Condition select; undefined encodings never branch.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            BR_BEQ:  taken = (a == b);
            BR_BNE:  taken = (a != b);
            BR_BLT:  taken = ($signed(a) < $signed(b));
            BR_BGE:  taken = !($signed(a) < $signed(b));
            BR_BLTU: taken = (a < b);
            BR_BGEU: taken = !(a < b);
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV-M unit: one shift-add / restoring-divide step per cycle on
// operand magnitudes, with the sign applied when the result is read in DONE.
module muldiv_iter import riscv_structures::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic            idle,
    output logic [XLEN-1:0] result
);
    localparam int              CW     = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_V  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES_V = {XLEN{1'b1}};
    localparam logic [CW-1:0]   LAST_V = CW'(XLEN-1);

    md_state_e         state_r, state_nxt_s;
    logic [CW-1:0]     count_r;
    logic [XLEN-1:0]   hi_r, lo_r, div_r;
    logic [2:0]        f3_r;
    logic              neg_r;
    logic              accept_s, a_neg_s, b_neg_s, is_div_s, div0_s, ovf_s, special_s, last_s;
    logic [XLEN-1:0]   a_mag_s, b_mag_s, div_val_s, div_fix_s;
    logic [XLEN:0]     mul_sum_s, div_shift_s, div_diff_s;
    logic [2*XLEN-1:0] prod_fix_s;

    assign accept_s  = start & ~flush & (state_r == MD_IDLE);
    assign a_neg_s   = md_a_signed(funct3) & op_a[XLEN-1];
    assign b_neg_s   = md_b_signed(funct3) & op_b[XLEN-1];
    assign a_mag_s   = a_neg_s ? -op_a : op_a;
    assign b_mag_s   = b_neg_s ? -op_b : op_b;
    assign is_div_s  = funct3[2];
    assign div0_s    = is_div_s & (op_b == '0);
    assign ovf_s     = is_div_s & ~funct3[0] & (op_a == MIN_V) & (op_b == ONES_V);
    assign special_s = div0_s | ovf_s;
    assign last_s    = (count_r == LAST_V);

    // {hi_r, lo_r} is the product/multiplier pair or the remainder/quotient pair.
    assign mul_sum_s   = lo_r[0] ? ({1'b0, hi_r} + {1'b0, div_r}) : {1'b0, hi_r};
    assign div_shift_s = {hi_r, lo_r[XLEN-1]};
    assign div_diff_s  = div_shift_s - {1'b0, div_r};

    assign prod_fix_s = neg_r ? -{hi_r, lo_r} : {hi_r, lo_r};
    assign div_val_s  = f3_r[1] ? hi_r : lo_r;
    assign div_fix_s  = neg_r ? -div_val_s : div_val_s;
    assign result     = f3_r[2] ? div_fix_s :
                        (f3_r[1:0] == 2'b00) ? prod_fix_s[XLEN-1:0] : prod_fix_s[2*XLEN-1:XLEN];

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= MD_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; special cases bypass the iteration entirely.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = MD_IDLE;
        end else begin
            case (state_r)
                MD_IDLE: begin
                    if (accept_s) begin
                        state_nxt_s = special_s ? MD_DONE : MD_RUN;
                    end else begin
                        state_nxt_s = MD_IDLE;
                    end
                end
                MD_RUN: begin
                    if (last_s) begin
                        state_nxt_s = MD_DONE;
                    end else begin
                        state_nxt_s = MD_RUN;
                    end
                end
                MD_DONE: state_nxt_s = MD_IDLE;
                default: state_nxt_s = MD_IDLE;
            endcase
        end
    end

    // FSM outputs; busy covers the accept cycle so upstream stalls immediately.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        idle = 1'b0;
        case (state_r)
            MD_IDLE: begin
                busy = accept_s;
                idle = 1'b1;
            end
            MD_RUN:  busy = 1'b1;
            MD_DONE: done = 1'b1;
            default: idle = 1'b1;
        endcase
    end

    // Operand latch and per-cycle iteration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
            div_r   <= '0;
            f3_r    <= 3'd0;
            neg_r   <= 1'b0;
        end else if (flush) begin
            count_r <= '0;
        end else if (accept_s) begin
            count_r <= '0;
            f3_r    <= funct3;
            div_r   <= b_mag_s;
            if (div0_s) begin
                hi_r  <= op_a;
                lo_r  <= ONES_V;
                neg_r <= 1'b0;
            end else if (ovf_s) begin
                hi_r  <= '0;
                lo_r  <= MIN_V;
                neg_r <= 1'b0;
            end else begin
                hi_r  <= '0;
                lo_r  <= a_mag_s;
                neg_r <= (is_div_s & funct3[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
            end
        end else if (state_r == MD_RUN) begin
            count_r <= count_r + CW'(1);
            if (f3_r[2]) begin
                if (!div_diff_s[XLEN]) begin
                    hi_r <= div_diff_s[XLEN-1:0];
                    lo_r <= {lo_r[XLEN-2:0], 1'b1};
                end else begin
                    hi_r <= div_shift_s[XLEN-1:0];
                    lo_r <= {lo_r[XLEN-2:0], 1'b0};
                end
            end else begin
                hi_r <= mul_sum_s[XLEN:1];
                lo_r <= {mul_sum_s[0], lo_r[XLEN-1:1]};
            end
        end
    end
endmodule

// File: rtl/execute_md.sv
// Execute stage: single-cycle ALU, branch resolution and operand bypass,
// plus an iterative RV-M unit that stalls upstream while it works.
module execute_md import riscv_structures::*; #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [3:0]        in_alu_op,
    input  logic [2:0]        in_funct3,
    input  logic              in_is_muldiv,
    input  logic              in_use_pc,
    input  logic              in_use_imm,
    input  logic              in_is_branch,
    input  logic              in_is_jump,
    input  logic              in_reg_write,
    input  logic              in_mem_write,
    input  logic              in_mem_read,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [1:0]        rs1_sel,
    input  logic [1:0]        rs2_sel,
    input  logic [XLEN-1:0]   bp_mem,
    input  logic [XLEN-1:0]   bp_wb,
    input  logic              flush,
    output logic              busy,
    output logic              pc_reset,
    output logic [XLEN-1:0]   pc_target,
    output logic              out_valid,
    output logic              out_reg_write,
    output logic              out_mem_write,
    output logic              out_mem_read,
    output logic [XLEN-1:0]   out_result,
    output logic [XLEN-1:0]   out_write_data,
    output logic [REG_AW-1:0] out_rd
);
    logic [XLEN-1:0] rs1_val_s, rs2_val_s, alu_a_s, alu_b_s, alu_y_s, md_result_s;
    logic            cmp_s, md_busy_s, md_done_s, md_idle_s;

    // rs1 bypass; encoding 3 falls back to the register file.
    always_comb begin
        rs1_val_s = in_rs1_data;
        case (ex_src_e'(rs1_sel))
            SRC_MEM: rs1_val_s = bp_mem;
            SRC_WB:  rs1_val_s = bp_wb;
            default: rs1_val_s = in_rs1_data;
        endcase
    end

    // rs2 bypass, same encoding as rs1.
    always_comb begin
        rs2_val_s = in_rs2_data;
        case (ex_src_e'(rs2_sel))
            SRC_MEM: rs2_val_s = bp_mem;
            SRC_WB:  rs2_val_s = bp_wb;
            default: rs2_val_s = in_rs2_data;
        endcase
    end

    assign alu_a_s = in_use_pc  ? in_pc  : rs1_val_s;
    assign alu_b_s = in_use_imm ? in_imm : rs2_val_s;

    alu #(.XLEN(XLEN)) u_alu (
        .op(in_alu_op), .a(alu_a_s), .b(alu_b_s), .y(alu_y_s)
    );

    compare #(.XLEN(XLEN)) u_cmp (
        .funct3(in_funct3), .a(rs1_val_s), .b(rs2_val_s), .taken(cmp_s)
    );

    muldiv_iter #(.XLEN(XLEN)) u_md (
        .clk(clk), .rst(rst), .flush(flush), .start(in_valid & in_is_muldiv),
        .funct3(in_funct3), .op_a(rs1_val_s), .op_b(rs2_val_s),
        .busy(md_busy_s), .done(md_done_s), .idle(md_idle_s), .result(md_result_s)
    );

    assign busy      = ~rst & md_busy_s;
    assign pc_reset  = ~rst & ~flush & in_valid & md_idle_s & ~in_is_muldiv &
                       ((in_is_branch & cmp_s) | in_is_jump);
    assign pc_target = rst ? '0 : alu_y_s;

    // EX/MEM register: flush, stall and empty slots load a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_reg_write  <= 1'b0;
            out_mem_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_result     <= '0;
            out_write_data <= '0;
            out_rd         <= '0;
        end else if (flush || md_busy_s || !in_valid) begin
            out_valid      <= 1'b0;
            out_reg_write  <= 1'b0;
            out_mem_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_result     <= '0;
            out_write_data <= '0;
            out_rd         <= '0;
        end else begin
            out_valid      <= 1'b1;
            out_reg_write  <= in_reg_write & in_valid;
            out_mem_write  <= in_mem_write & in_valid;
            out_mem_read   <= in_mem_read & in_valid;
            out_result     <= md_done_s ? md_result_s : alu_y_s;
            out_write_data <= rs2_val_s;
            out_rd         <= in_rd;
        end
    end
endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md with an expected-result queue.
module tb_execute_md;
    import riscv_structures::*;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_is_muldiv, in_use_pc, in_use_imm, in_is_branch, in_is_jump;
    logic              in_reg_write, in_mem_write, in_mem_read, flush;
    logic [XLEN-1:0]   in_pc, in_rs1_data, in_rs2_data, in_imm, bp_mem, bp_wb;
    logic [3:0]        in_alu_op;
    logic [2:0]        in_funct3;
    logic [REG_AW-1:0] in_rd;
    logic [1:0]        rs1_sel, rs2_sel;
    logic              busy, pc_reset, out_valid, out_reg_write, out_mem_write, out_mem_read;
    logic [XLEN-1:0]   pc_target, out_result, out_write_data;
    logic [REG_AW-1:0] out_rd;

    typedef struct {
        logic [XLEN-1:0]   result;
        logic [XLEN-1:0]   wdata;
        logic [REG_AW-1:0] rd;
        logic              rw, mw, mr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    execute_md #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_alu_op(in_alu_op), .in_funct3(in_funct3), .in_is_muldiv(in_is_muldiv),
        .in_use_pc(in_use_pc), .in_use_imm(in_use_imm), .in_is_branch(in_is_branch),
        .in_is_jump(in_is_jump), .in_reg_write(in_reg_write), .in_mem_write(in_mem_write),
        .in_mem_read(in_mem_read), .in_rd(in_rd), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
        .bp_mem(bp_mem), .bp_wb(bp_wb), .flush(flush), .busy(busy), .pc_reset(pc_reset),
        .pc_target(pc_target), .out_valid(out_valid), .out_reg_write(out_reg_write),
        .out_mem_write(out_mem_write), .out_mem_read(out_mem_read), .out_result(out_result),
        .out_write_data(out_write_data), .out_rd(out_rd)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_is_muldiv = 1'b0; in_use_pc = 1'b0; in_use_imm = 1'b0;
        in_is_branch = 1'b0; in_is_jump = 1'b0; in_reg_write = 1'b0; in_mem_write = 1'b0;
        in_mem_read = 1'b0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
        bp_mem = '0; bp_wb = '0; in_alu_op = ALU_ADD; in_funct3 = 3'd0; in_rd = '0;
        rs1_sel = 2'd0; rs2_sel = 2'd0;
    endtask

    task automatic push(input logic [XLEN-1:0] r, input logic [XLEN-1:0] wd,
                        input logic [REG_AW-1:0] rd, input logic rw, input logic mw, input logic mr);
        exp_t e;
        e.result = r; e.wdata = wd; e.rd = rd; e.rw = rw; e.mw = mw; e.mr = mr;
        sb.push_back(e);
    endtask

    // One clock; any valid output is matched against the oldest expectation.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", out_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check("sb_result", out_result, e.result);
                check("sb_wdata", out_write_data, e.wdata);
                check("sb_rd", out_rd, e.rd);
                check("sb_reg_write", out_reg_write, e.rw);
                check("sb_mem_write", out_mem_write, e.mw);
                check("sb_mem_read", out_mem_read, e.mr);
            end
        end
    endtask

    task automatic run_md(input string tag, input logic [2:0] f3, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int cyc);
        int n = 0;
        idle_inputs();
        in_valid = 1'b1; in_is_muldiv = 1'b1; in_funct3 = f3;
        in_rs1_data = a; in_rs2_data = b; in_rd = 5'd9; in_reg_write = 1'b1;
        #1;
        check({tag, "_busy_accept"}, busy, 1'b1);
        push(exp, b, 5'd9, 1'b1, 1'b0, 1'b0);
        while (busy === 1'b1 && n < 200) begin
            n++;
            tick();
            check({tag, "_bubble"}, out_valid, 1'b0);
        end
        check({tag, "_stall_len"}, n, cyc);
        tick();
        check({tag, "_valid"}, out_valid, 1'b1);
        idle_inputs();
        tick();
        check({tag, "_one_shot"}, out_valid, 1'b0);
    endtask

    initial begin
        idle_inputs();
        flush = 1'b0;
        rst = 1'b1;
        in_valid = 1'b1; in_is_jump = 1'b1; in_rs1_data = 32'h44; in_reg_write = 1'b1;
        repeat (2) tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_result", out_result, 32'h0);
        check("rst_out_reg_write", out_reg_write, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pc_reset", pc_reset, 1'b0);
        check("rst_pc_target", pc_target, 32'h0);
        rst = 1'b0;
        idle_inputs();
        tick();

        // ADD with rs1 from the MEM bypass
        idle_inputs();
        in_valid = 1'b1; rs1_sel = 2'd1; bp_mem = 32'h10; in_rs1_data = 32'hdead;
        in_imm = 32'd5; in_use_imm = 1'b1; in_rd = 5'd3; in_reg_write = 1'b1;
        #1;
        check("add_busy", busy, 1'b0);
        check("add_pc_reset", pc_reset, 1'b0);
        push(32'h15, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        check("add_valid", out_valid, 1'b1);

        // store: rs1 select 3 falls back to RF, rs2 from WB bypass
        idle_inputs();
        in_valid = 1'b1; rs1_sel = 2'd3; in_rs1_data = 32'h200; bp_mem = 32'h999;
        bp_wb = 32'hcafe; rs2_sel = 2'd2; in_rs2_data = 32'h1111;
        in_imm = 32'd8; in_use_imm = 1'b1; in_mem_write = 1'b1;
        push(32'h208, 32'hcafe, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();

        // SLT signed, then SRA by immediate
        idle_inputs();
        in_valid = 1'b1; in_alu_op = ALU_SLT; in_rs1_data = 32'hffffffff; in_rs2_data = 32'h1;
        in_rd = 5'd4; in_reg_write = 1'b1;
        push(32'h1, 32'h1, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        in_alu_op = ALU_SRA; in_rs1_data = 32'h80000000; in_imm = 32'd4; in_use_imm = 1'b1;
        in_mem_read = 1'b1;
        push(32'hf8000000, 32'h1, 5'd4, 1'b1, 1'b0, 1'b1);
        tick();

        // bubble: enables asserted but no live instruction
        idle_inputs();
        in_reg_write = 1'b1; in_mem_write = 1'b1;
        tick();
        check("bubble_valid", out_valid, 1'b0);
        check("bubble_reg_write", out_reg_write, 1'b0);

        run_md("mul", F3_MUL, 32'd7, 32'hfffffffd, 32'hffffffeb, 33);
        run_md("mulhu", F3_MULHU, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 33);
        run_md("mulhsu", F3_MULHSU, 32'hffffffff, 32'd2, 32'hffffffff, 33);
        run_md("div0", F3_DIV, 32'd5, 32'd0, 32'hffffffff, 1);
        run_md("rem0", F3_REM, 32'd5, 32'd0, 32'd5, 1);
        run_md("div_ovf", F3_DIV, 32'h80000000, 32'hffffffff, 32'h80000000, 1);
        run_md("rem_ovf", F3_REM, 32'h80000000, 32'hffffffff, 32'h0, 1);
        run_md("div_neg", F3_DIV, 32'hfffffff9, 32'd2, 32'hfffffffd, 33);
        run_md("rem_neg", F3_REM, 32'hfffffff9, 32'd2, 32'hffffffff, 33);

        // branches
        idle_inputs();
        in_valid = 1'b1; in_pc = 32'h100; in_imm = 32'h20; in_use_pc = 1'b1; in_use_imm = 1'b1;
        in_is_branch = 1'b1; in_funct3 = BR_BEQ; in_rs1_data = 32'h42; in_rs2_data = 32'h42;
        #1;
        check("beq_taken", pc_reset, 1'b1);
        check("beq_target", pc_target, 32'h120);
        flush = 1'b1;
        #1;
        check("beq_flush_gate", pc_reset, 1'b0);
        flush = 1'b0;
        in_rs2_data = 32'h43;
        #1;
        check("beq_not_taken", pc_reset, 1'b0);
        push(32'h120, 32'h43, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        in_funct3 = BR_BLT; in_rs1_data = 32'hffffffff; in_rs2_data = 32'h1;
        #1;
        check("blt_taken", pc_reset, 1'b1);
        push(32'h120, 32'h1, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();

        // flush a DIVU at iteration 10
        idle_inputs();
        in_valid = 1'b1; in_is_muldiv = 1'b1; in_funct3 = F3_DIVU;
        in_rs1_data = 32'd100; in_rs2_data = 32'd7; in_rd = 5'd9; in_reg_write = 1'b1;
        #1;
        check("flush_accept", busy, 1'b1);
        repeat (11) tick();
        check("flush_busy_run", busy, 1'b1);
        idle_inputs();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy_drop", busy, 1'b0);
        check("flush_out_valid", out_valid, 1'b0);
        in_valid = 1'b1; in_rs1_data = 32'd3; in_rs2_data = 32'd4; in_rd = 5'd6; in_reg_write = 1'b1;
        #1;
        check("post_flush_busy", busy, 1'b0);
        push(32'd7, 32'd4, 5'd6, 1'b1, 1'b0, 1'b0);
        tick();
        check("post_flush_valid", out_valid, 1'b1);
        idle_inputs();
        repeat (40) tick();

        // asynchronous reset mid-RUN
        idle_inputs();
        in_valid = 1'b1; in_is_muldiv = 1'b1; in_funct3 = F3_MUL;
        in_rs1_data = 32'd7; in_rs2_data = 32'd9; in_rd = 5'd9; in_reg_write = 1'b1;
        repeat (5) tick();
        check("pre_rst_busy", busy, 1'b1);
        check("pre_rst_target", pc_target, 32'd16);
        #2;
        rst = 1'b1;
        #1;
        check("rst_run_busy", busy, 1'b0);
        check("rst_run_target", pc_target, 32'h0);
        check("rst_run_valid", out_valid, 1'b0);
        check("rst_run_result", out_result, 32'h0);
        repeat (3) tick();
        rst = 1'b0;
        idle_inputs();
        repeat (40) tick();
        run_md("remu", F3_REMU, 32'd17, 32'd5, 32'd2, 33);

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/execute_md.md
Name: execute_md

Overview:
Parametrised successor to the single-cycle execute stage. It keeps the same single-cycle ALU, branch-resolution and bypass-mux behaviour, and adds an iterative RV-M multiply/divide unit. That unit stalls upstream through a busy handshake.
Sits between decode and memory stages. Drives the EX/MEM pipeline register and the fetch redirect.

Parameters:
XLEN, 32, datapath width (32 or 64)
REG_AW, 5, register index width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  decode slot holds a live instruction
in_pc  in  XLEN  instruction PC
in_rs1_data, in_rs2_data  in  XLEN  register-file operands
in_imm  in  XLEN  sign-extended immediate
in_alu_op  in  4  existing alu opcode
in_funct3  in  3  branch condition / M-op select
in_is_muldiv  in  1  instruction is an RV-M op
in_use_pc, in_use_imm, in_is_branch, in_is_jump  in  1 each  operand/control selects
in_reg_write, in_mem_write, in_mem_read  in  1 each  write-back/memory controls
in_rd  in  REG_AW  destination register
rs1_sel, rs2_sel  in  2  bypass select: 0=RF, 1=MEM, 2=WB
bp_mem, bp_wb  in  XLEN  bypass values
flush  in  1  kill the current instruction and any in-flight M-op
busy  out  1  stall request: decode and fetch hold
pc_reset  out  1  redirect fetch
pc_target  out  XLEN  redirect address
out_valid, out_reg_write, out_mem_write, out_mem_read  out  1 each  EX/MEM controls, valid-gated
out_result, out_write_data  out  XLEN  ALU/M result; store data (forwarded rs2)
out_rd  out  REG_AW  destination register

Behaviour:
- Reset: all out_* = 0, FSM = IDLE. busy, pc_reset and pc_target are 0 while rst is high.
- Operand mux: rs1/rs2 value = bp_mem if sel==1, bp_wb if sel==2, RF data otherwise (3 treated as RF).
  - ALU in1 = pc if use_pc, else rs1 value.
  - ALU in2 = imm if use_imm, else rs2 value.
- Non-M op, in_valid, FSM IDLE: out_* registered at the next edge (1-cycle latency).
  - out_valid = 1; reg_write, mem_write and mem_read are each ANDed with in_valid.
  - !in_valid produces a bubble: out_valid and all enables = 0.
- Redirect (combinational): pc_reset = in_valid & FSM IDLE & !in_is_muldiv & ((in_is_branch & cmp) | in_is_jump). pc_target = ALU result.
- M-op FSM: IDLE -> RUN -> DONE -> IDLE.
  - Accept: in_valid & in_is_muldiv & IDLE & !flush. Forwarded operands and funct3 are latched; count = 0.
  - busy = accept | (state == RUN). busy is therefore combinationally high in the accept cycle.
  - RUN: one iteration per cycle, XLEN cycles, then DONE.
    - MUL, MULH, MULHSU, MULHU: shift-add over a 2*XLEN product with sign correction.
    - DIV, DIVU, REM, REMU: restoring division on magnitudes, with sign fix-up at DONE.
  - Special cases skip RUN and go IDLE -> DONE:
    - Divide by zero: quotient = all ones, remainder = dividend.
    - Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
  - DONE: busy = 0. At the next edge the M result loads out_* (out_valid = 1, reg_write gated) and FSM returns to IDLE. Upstream advances on the same edge. DONE never re-accepts.
  - While busy, out_valid is 0 each edge, i.e. bubbles.
  - Stall length: XLEN+1 cycles. Result is visible XLEN+2 edges after presentation.
- Upstream holds all in_* stable while busy=1. Bypass values may change; latched operands are unaffected.
- flush (synchronous, highest priority):
  - Next edge: out_valid = 0 and enables = 0; FSM -> IDLE; iteration state discarded.
  - pc_reset is forced to 0 in the same cycle.
- rst asserted mid-RUN: immediate return to IDLE, outputs 0, no partial result ever emitted.
- Widths: all arithmetic is modulo XLEN. MULH* return the upper XLEN bits of the 2*XLEN product.

Decomposition:
- Shared package (riscv_structures):
  - ex_src_e bypass enum (RF/MEM/WB).
  - md_state_e.
  - M funct3 constants: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- Existing alu and compare modules are instantiated unchanged.
- One new sub-module, muldiv_iter:
  - Handles start/operands/funct3, busy/done/result.
  - Owns the FSM, iteration counter, special-case detection and sign fix-up.

Test Plan:
- ADD x3 with rs1_sel=MEM (bp_mem=0x10), in_imm=5, use_imm -> next edge out_result=0x15, out_valid=1, busy stays 0.
- MUL 7 * 0xFFFFFFFD (XLEN=32) -> busy high 33 cycles, out_valid=0 throughout, then out_result=0xFFFFFFEB for exactly one valid cycle. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0. Each has a 1-cycle busy.
- BEQ (use_pc, is_branch) with equal operands, pc=0x100, imm=0x20 -> pc_reset=1, pc_target=0x120 combinationally. With unequal operands, pc_reset=0.
- DIVU in RUN, flush at count 10 -> busy drops the next cycle, no valid result emitted, and a following ADD completes with 1-cycle latency.
- rst pulsed asynchronously mid-RUN -> all outputs 0 immediately. After release, a REMU 17/5 -> out_result=2.
